// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: program memory sequencer arbitrating boot-loader writes and CPU fetch reads.
module prog_mem_ctrl #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DATA_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  input  logic                 fetch_req,
  output logic                 fetch_gnt,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_rvalid,
  output logic [DATA_SIZE-1:0] fetch_data,
  output logic                 fetch_err,
  output logic                 cpu_run,
  output logic [ADDR_SIZE:0]   prog_len,
  output logic                 mem_W,
  output logic [ADDR_SIZE-1:0] mem_ADDR,
  output logic [DATA_SIZE-1:0] mem_DATA_WR,
  input  logic [DATA_SIZE-1:0] mem_DATA
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0] prog_len_q, prog_len_d;
  logic rvalid_q, err_q, in_load, wr_en, full;
  assign in_load      = state_q == LOAD;
  assign wr_en        = in_load & ld_valid & ~ld_start;
  assign full         = &wr_ptr_q;
  assign ld_ready     = in_load;
  assign cpu_run      = state_q == RUN;
  assign fetch_gnt    = cpu_run & fetch_req;
  assign mem_W        = wr_en;
  assign mem_ADDR     = in_load ? wr_ptr_q : fetch_addr;
  assign mem_DATA_WR  = ld_data;
  assign fetch_data   = mem_DATA;
  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = err_q;
  assign prog_len     = prog_len_q;
  // the pointer parks on the last address when memory fills; only LOAD re-entry clears it
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    if (ld_start) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      prog_len_d = '0;
    end else if (wr_en) begin
      prog_len_d = prog_len_q + (ADDR_SIZE+1)'(1);
      wr_ptr_d   = full ? wr_ptr_q : wr_ptr_q + ADDR_SIZE'(1);
      state_d    = (ld_last | full) ? RUN : LOAD;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      rvalid_q   <= fetch_gnt;
      err_q      <= fetch_gnt & ({1'b0, fetch_addr} >= prog_len_q);
    end
  end
endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb_prog_mem_ctrl: directed and randomized checks of prog_mem_ctrl against a program-level model.
module tb_prog_mem_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  logic ld_start = 0, ld_valid = 0, ld_last = 0, fetch_req = 0;
  logic [15:0] ld_data = '0;
  logic [3:0] fetch_addr = '0;
  logic ld_ready, fetch_gnt, fetch_rvalid, fetch_err, cpu_run, mem_W;
  logic [15:0] fetch_data, mem_DATA_WR, mem_DATA;
  logic [4:0] prog_len;
  logic [3:0] mem_ADDR;
  logic [15:0] mem [16];
  logic [15:0] exp_mem [16];
  logic loading = 0, running = 0;
  int exp_len = 0, errors = 0, checks = 0;

  prog_mem_ctrl #(.DATA_SIZE(16), .ADDR_SIZE(4)) dut (
    .clk(clk), .rstn(rstn), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .fetch_req(fetch_req), .fetch_gnt(fetch_gnt),
    .fetch_addr(fetch_addr), .fetch_rvalid(fetch_rvalid), .fetch_data(fetch_data),
    .fetch_err(fetch_err), .cpu_run(cpu_run), .prog_len(prog_len), .mem_W(mem_W),
    .mem_ADDR(mem_ADDR), .mem_DATA_WR(mem_DATA_WR), .mem_DATA(mem_DATA)
  );

  always #5 clk = ~clk;

  // program memory with registered read data
  always @(posedge clk) begin
    if (mem_W) mem[mem_ADDR] <= mem_DATA_WR;
    mem_DATA <= mem[mem_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive inputs, check combinational outputs, advance model, check registered outputs
  task automatic step(input logic st, input logic v, input logic last, input logic [15:0] d,
                      input logic req, input logic [3:0] fa);
    logic g;
    logic [3:0] gaddr;
    int glen;
    ld_start = st; ld_valid = v; ld_last = last; ld_data = d; fetch_req = req; fetch_addr = fa;
    #1;
    chk("ld_ready", ld_ready, loading);
    chk("fetch_gnt", fetch_gnt, running & req);
    chk("mem_W", mem_W, loading & v & ~st);
    chk("mem_ADDR", mem_ADDR, loading ? exp_len : fa);
    chk("mem_DATA_WR", mem_DATA_WR, d);
    g = running & req; gaddr = fa; glen = exp_len;
    if (st) begin
      loading = 1; running = 0; exp_len = 0;
    end else if (loading & v) begin
      exp_mem[exp_len] = d;
      exp_len++;
      if (last || exp_len == 16) begin loading = 0; running = 1; end
    end
    @(posedge clk); @(negedge clk);
    chk("fetch_rvalid", fetch_rvalid, g);
    if (g) chk("fetch_err", fetch_err, int'(gaddr) >= glen);
    if (g && int'(gaddr) < glen) chk("fetch_data", fetch_data, exp_mem[gaddr]);
    chk("prog_len", prog_len, exp_len);
    chk("cpu_run", cpu_run, running);
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0, 4'h0);
  endtask

  initial begin
    // reset
    @(negedge clk); @(negedge clk);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_rvalid", fetch_rvalid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_mem_W", mem_W, 0);
    rstn = 1;
    // loader words ignored in IDLE
    step(0, 1, 1, 16'hDEAD, 1, 4'h0);
    // three-word load
    step(1, 0, 0, 16'h0, 0, 4'h0);
    step(0, 1, 0, 16'hA001, 0, 4'h0);
    step(0, 1, 0, 16'hA002, 0, 4'h0);
    step(0, 1, 1, 16'hA003, 0, 4'h0);
    chk("mem0", mem[0], 16'hA001);
    chk("mem1", mem[1], 16'hA002);
    chk("mem2", mem[2], 16'hA003);
    chk("len3", prog_len, 3);
    // back-to-back fetches, in range then out of range
    step(0, 0, 0, 16'h0, 1, 4'h1);
    chk("fetch1_data", fetch_data, 16'hA002);
    chk("fetch1_err", fetch_err, 0);
    step(0, 0, 0, 16'h0, 1, 4'h5);
    chk("fetch5_err", fetch_err, 1);
    idle();
    // restart from RUN with a fetch in the same cycle
    step(1, 0, 0, 16'h0, 1, 4'h2);
    chk("restart_data", fetch_data, 16'hA003);
    // full load without ld_last
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'($urandom), 0, 4'h0);
    chk("full_len", prog_len, 16);
    step(0, 1, 1, 16'h5555, 0, 4'h0);
    step(0, 0, 0, 16'h0, 1, 4'hF);
    step(0, 0, 0, 16'h0, 1, 4'h0);
    idle();
    // loader backpressure
    step(1, 0, 0, 16'h0, 0, 4'h0);
    for (int i = 0; i < 6; i++) step(0, (i % 2) == 0, i == 4, 16'($urandom), 0, 4'h0);
    chk("bp_len", prog_len, 3);
    for (int a = 0; a < 3; a++) step(0, 0, 0, 16'h0, 1, 4'(a));
    // restart mid-load after two words
    step(1, 0, 0, 16'h0, 0, 4'h0);
    step(0, 1, 0, 16'h1111, 0, 4'h0);
    step(0, 1, 0, 16'h2222, 0, 4'h0);
    step(1, 1, 0, 16'h3333, 0, 4'h0);
    step(0, 1, 0, 16'h4444, 0, 4'h0);
    chk("restart_mem0", mem[0], 16'h4444);
    for (int i = 0; i < 4; i++) step(0, $urandom_range(0, 1) == 1, i == 3, 16'($urandom), 0, 4'h0);
    // randomized fetch traffic
    for (int i = 0; i < 30; i++) step(0, $urandom_range(0, 1) == 1, 0, 16'($urandom),
                                      $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    // asynchronous reset mid-load
    step(1, 0, 0, 16'h0, 0, 4'h0);
    step(0, 1, 0, 16'h7777, 0, 4'h0);
    step(0, 1, 0, 16'h8888, 0, 4'h0);
    ld_valid = 1; fetch_req = 1;
    rstn = 0;
    #1;
    chk("amid_cpu_run", cpu_run, 0);
    chk("amid_prog_len", prog_len, 0);
    chk("amid_ld_ready", ld_ready, 0);
    chk("amid_mem_W", mem_W, 0);
    chk("amid_gnt", fetch_gnt, 0);
    chk("amid_rvalid", fetch_rvalid, 0);
    loading = 0; running = 0; exp_len = 0;
    @(negedge clk);
    rstn = 1;
    step(0, 1, 0, 16'h9999, 1, 4'h0);
    step(0, 1, 1, 16'h9999, 0, 4'h0);
    step(1, 0, 0, 16'h0, 0, 4'h0);
    step(0, 1, 1, 16'hBEEF, 0, 4'h0);
    step(0, 0, 0, 16'h0, 1, 4'h0);
    chk("final_data", fetch_data, 16'hBEEF);
    step(0, 0, 0, 16'h0, 1, 4'h1);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mem_ctrl.md
# prog_mem_ctrl

Sequencer and arbiter in front of the program memory. It owns the memory's write-enable, address and write-data pins and shares them between a boot loader, which streams instruction words in at auto-incrementing addresses, and the CPU instruction-fetch port, which reads. It holds the CPU stalled (`cpu_run=0`) until a load completes and tracks the loaded program length so that fetches beyond it are flagged.

## Interface
- `DATA_SIZE`, 16, instruction word width; must match the program memory.
- `ADDR_SIZE`, 4, address width; memory depth is 2**ADDR_SIZE words.

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ld_start`  in  1  one-cycle pulse; starts or restarts a load at address 0.
- `ld_valid`  in  1  loader word valid.
- `ld_ready`  out  1  controller accepts a loader word.
- `ld_data`  in  DATA_SIZE  loader word.
- `ld_last`  in  1  qualifies `ld_valid`; this word is the final one of the program.
- `fetch_req`  in  1  CPU read request.
- `fetch_gnt`  out  1  the read request is accepted this cycle.
- `fetch_addr`  in  ADDR_SIZE  CPU read address.
- `fetch_rvalid`  out  1  `fetch_data` is valid.
- `fetch_data`  out  DATA_SIZE  read data, driven straight through from `mem_DATA`.
- `fetch_err`  out  1  qualifies `fetch_rvalid`; the address was at or beyond `prog_len`.
- `cpu_run`  out  1  a program is loaded and the CPU may run.
- `prog_len`  out  ADDR_SIZE+1  number of words written in the current or last load.
- `mem_W`  out  1  to the program memory write enable.
- `mem_ADDR`  out  ADDR_SIZE  to the program memory address.
- `mem_DATA_WR`  out  DATA_SIZE  to the program memory write data.
- `mem_DATA`  in  DATA_SIZE  from the program memory registered read data.

## Operation
- FSM states:
  - IDLE (reset state).
  - LOAD.
  - RUN.
- IDLE:
  - `ld_ready=0`, `fetch_gnt=0`, `cpu_run=0`.
  - `ld_start` moves to LOAD.
- LOAD:
  - `ld_ready=1`. A word is accepted on `ld_valid & ld_ready`.
  - Each accepted word is written at `wr_ptr`; then `wr_ptr` and `prog_len` increment.
  - Load ends when the accepted word has `ld_last=1`, or when it is written at address 2**ADDR_SIZE-1 (memory full). The FSM then moves to RUN.
  - `ld_last` without `ld_valid` is ignored.
- RUN:
  - `cpu_run=1`. `fetch_gnt = fetch_req`.
  - `ld_ready=0`; loader words are ignored.
  - `ld_start` moves to LOAD.
- On LOAD entry (from any state):
  - `wr_ptr=0`, `prog_len=0`, `cpu_run=0` from the next cycle on.
- `ld_start` during LOAD: the write in that cycle is suppressed and the load restarts at 0.
- Memory pins, combinational from state and inputs:
  - In LOAD: `mem_W = ld_valid & ~ld_start`, `mem_ADDR = wr_ptr`.
  - Otherwise: `mem_W=0`, `mem_ADDR = fetch_addr`.
  - `mem_DATA_WR = ld_data` always.
- Width rules:
  - `wr_ptr` is ADDR_SIZE bits and wraps to 0 only via LOAD re-entry; it never wraps silently.
  - `prog_len` is ADDR_SIZE+1 bits, so it can reach 2**ADDR_SIZE.
- `fetch_err` is computed with a zero-extended compare: `fetch_addr >= prog_len`. It is registered with `fetch_rvalid`.

## Timing
- Reset values of all outputs and state:
  - State IDLE, `wr_ptr=0`, `prog_len=0`.
  - `cpu_run=0`, `fetch_rvalid=0`, `fetch_err=0`.
  - `ld_ready=0`, `fetch_gnt=0`, `mem_W=0`.
  - Applies immediately on `rstn` low, regardless of any load or fetch in progress.
- Write latency:
  - A word accepted in cycle N is in memory at the edge ending cycle N.
  - `prog_len` shows the new count in cycle N+1.
- Load completion:
  - The final word is accepted in cycle N; the FSM is in RUN with `cpu_run=1` in cycle N+1.
  - The first fetch can be granted in N+1.
- Read latency is one cycle:
  - A request granted in cycle N gives `fetch_rvalid=1`, `fetch_data` and `fetch_err` in cycle N+1.
  - Back-to-back grants give one rvalid per cycle.
- `ld_start` in RUN at cycle N:
  - A fetch granted in N still returns rvalid in N+1.
  - The FSM is in LOAD in N+1, so no grant is issued in N+1.
- `fetch_rvalid` is never asserted 2 or more cycles after the last grant.

## Test plan
- Load of 3 words: reset, `ld_start`, then 3 words 0xA001, 0xA002, 0xA003 with `ld_last` on the third. Required: writes at addresses 0, 1, 2; `prog_len=3`; `cpu_run=1` in the cycle after the third word.
- Fetch after load: fetch addresses 1 then 5 in consecutive cycles. Required: rvalid with data 0xA002 and `fetch_err=0`, then rvalid with `fetch_err=1`, each one cycle after its grant.
- Full load with ADDR_SIZE=4: 16 words, `ld_last` never asserted. Required: automatic RUN after address 15; `prog_len=16`; the 17th `ld_valid` is ignored with `ld_ready=0`.
- Loader backpressure: `ld_valid` toggled every other cycle during LOAD. Required: writes only on valid cycles and no address is skipped.
- Restart and reload:
  - `ld_start` mid-load after 2 words. Required: `prog_len` returns to 0 and the next word is written at address 0.
  - `ld_start` in RUN with `fetch_req` in the same cycle. Required: that fetch returns; `cpu_run` drops the next cycle.
- Reset mid-load: `rstn` pulsed low after 2 words. Required: all outputs at reset values immediately; state IDLE; `ld_valid` ignored until a new `ld_start`.
